// File: rtl/cache_pkg.sv
// cache_pkg: shared line geometry and arbiter FSM encoding for the cache subsystem
package cache_pkg;
  localparam int WORD_NUM          = 4;
  localparam int WORD_OFFSET_WIDTH = 2;
  localparam int BYTE_OFFSET_WIDTH = 2;
  localparam int WORD_LSB          = BYTE_OFFSET_WIDTH;
  localparam int LINE_LSB          = BYTE_OFFSET_WIDTH + WORD_OFFSET_WIDTH;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_WAIT  = 2'b10;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational round-robin picker (fixed priority when ARB_FIXED_PRIO_EN is defined)
module arb_rr_pick #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^rr_ptr;
`endif
  logic [N-1:0] cand;
  // candidates at/after rr_ptr first, wrapping to the full set; lowest set bit wins
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    cand = pending;
`else
    cand = pending & ~((N'(1) << rr_ptr) - N'(1));
    cand = (|cand) ? cand : pending;
`endif
    idx = '0;
    for (int j = N - 1; j >= 0; j--) if (cand[j]) idx = PW'(j);
    gnt = cand & ~(cand - N'(1));
  end
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory port among N_REQ cache controllers with critical-word-first line refills (ARB_FIXED_PRIO_EN selects fixed priority)
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int N_REQ             = 2,
  parameter int ADR_WIDTH         = 32,
  parameter int WORD_WIDTH        = 32,
  parameter int WORD_NUM          = cache_pkg::WORD_NUM,
  parameter int WORD_OFFSET_WIDTH = cache_pkg::WORD_OFFSET_WIDTH,
  parameter int BYTE_OFFSET_WIDTH = cache_pkg::BYTE_OFFSET_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_cc2arb,
  input  logic [N_REQ*ADR_WIDTH-1:0]   adr_cc2arb,
  output logic [N_REQ-1:0]             ack_arb2cc,
  output logic [WORD_WIDTH-1:0]        dat_arb2cc,
  output logic [WORD_OFFSET_WIDTH-1:0] word_arb2cc,
  output logic [N_REQ-1:0]             gnt_arb2cc,
  output logic                         req_arb2mem,
  output logic [ADR_WIDTH-1:0]         adr_arb2mem,
  input  logic                         ack_mem2arb,
  input  logic [WORD_WIDTH-1:0]        dat_mem2arb,
  output logic                         err_arb
);
  localparam int PW  = $clog2(N_REQ);
  localparam int CW  = WORD_OFFSET_WIDTH + 1;
  localparam int LSB = WORD_OFFSET_WIDTH + BYTE_OFFSET_WIDTH;
  logic [1:0]                   state;
  logic [N_REQ-1:0]             pending, pick_gnt, win_oh, clr, set, drop;
  logic [PW-1:0]                rr_ptr, win, pick_idx;
  logic [CW-1:0]                cnt;
  logic [ADR_WIDTH-1:0]         adr_q [N_REQ];
  logic [ADR_WIDTH-1:0]         line_adr;
  logic [WORD_OFFSET_WIDTH-1:0] word;
  logic                         ack_ok, last, err;
  arb_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .pending(pending),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt),
    .idx    (pick_idx)
  );
  assign line_adr    = adr_q[win];
  assign word        = line_adr[BYTE_OFFSET_WIDTH +: WORD_OFFSET_WIDTH] + cnt[WORD_OFFSET_WIDTH-1:0];
  assign ack_ok      = (state == ST_WAIT) && ack_mem2arb;
  assign last        = ack_ok && (cnt == CW'(WORD_NUM - 1));
  assign clr         = last ? win_oh : '0;
  assign set         = req_cc2arb & (~pending | clr);
  assign drop        = req_cc2arb & pending & ~clr;
  assign req_arb2mem = (state == ST_ISSUE);
  assign adr_arb2mem = req_arb2mem ? {line_adr[ADR_WIDTH-1:LSB], word, {BYTE_OFFSET_WIDTH{1'b0}}} : '0;
  assign gnt_arb2cc  = win_oh;
  assign ack_arb2cc  = ack_ok ? win_oh : '0;
  assign dat_arb2cc  = ack_ok ? dat_mem2arb : '0;
  assign word_arb2cc = ack_ok ? word : '0;
  assign err_arb     = err;
  // pending capture: a new request beats the clear of a completing burst; a repeat request while pending is dropped and flagged
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pending <= '0;
      err     <= 1'b0;
      for (int i = 0; i < N_REQ; i++) adr_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) if (set[i]) adr_q[i] <= adr_cc2arb[i*ADR_WIDTH +: ADR_WIDTH];
      pending <= (pending & ~clr) | set;
      err     <= err | (|drop) | (ack_mem2arb && state != ST_WAIT);
    end
  // burst sequencer: IDLE picks an owner, then ISSUE/WAIT once per word of the line
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= ST_IDLE;
      win    <= '0;
      win_oh <= '0;
      cnt    <= '0;
    end else if (state == ST_IDLE && |pending) begin
      state  <= ST_ISSUE;
      win    <= pick_idx;
      win_oh <= pick_gnt;
      cnt    <= '0;
    end else if (state == ST_ISSUE) begin
      state <= ST_WAIT;
    end else if (ack_ok) begin
      state  <= last ? ST_IDLE : ST_ISSUE;
      cnt    <= cnt + 1'b1;
      win_oh <= last ? '0 : win_oh;
    end
`ifdef ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  // round-robin pointer moves just past the owner of each finished burst
  always_ff @(posedge clk or negedge rst)
    if (!rst) rr_ptr <= '0;
    else if (last) rr_ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
`endif
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b0;
  logic [1:0]  req_main = '0, req_fair = '0, re_en = '0;
  logic [63:0] adr_main = '0;
  logic [1:0]  req_cc2arb, ack_arb2cc, gnt_arb2cc, word_arb2cc;
  logic [31:0] dat_arb2cc, adr_arb2mem, dat_mem2arb;
  logic        req_arb2mem, ack_mem2arb, err_arb;
  logic        resp_ack = 1'b0, tb_ack = 1'b0, mem_en = 1'b1;
  logic [31:0] resp_dat = '0, tb_dat = '0, resp_a = '0;
  int          checks = 0, failures = 0, cyc = 0, t0 = 0;
  logic [31:0] iss_adr [$];
  logic [31:0] ack_dat [$];
  logic [1:0]  iss_gnt [$];
  logic [1:0]  ack_who [$];
  logic [1:0]  ack_word [$];
  int          iss_cyc [$];
  int          ack_cyc [$];
  int          rc [2];
  logic        fire;

  assign req_cc2arb  = req_main | req_fair;
  assign ack_mem2arb = resp_ack | tb_ack;
  assign dat_mem2arb = resp_dat | tb_dat;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req_cc2arb(req_cc2arb), .adr_cc2arb(adr_main),
    .ack_arb2cc(ack_arb2cc), .dat_arb2cc(dat_arb2cc), .word_arb2cc(word_arb2cc),
    .gnt_arb2cc(gnt_arb2cc), .req_arb2mem(req_arb2mem), .adr_arb2mem(adr_arb2mem),
    .ack_mem2arb(ack_mem2arb), .dat_mem2arb(dat_mem2arb), .err_arb(err_arb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: log every memory request and every controller ack
  always @(negedge clk) begin
    if (!rst) begin
      iss_adr.delete(); iss_gnt.delete(); iss_cyc.delete();
      ack_who.delete(); ack_word.delete(); ack_dat.delete(); ack_cyc.delete();
    end else begin
      if (req_arb2mem) begin
        iss_adr.push_back(adr_arb2mem); iss_gnt.push_back(gnt_arb2cc); iss_cyc.push_back(cyc);
      end
      if (ack_arb2cc != 2'b00) begin
        ack_who.push_back(ack_arb2cc); ack_word.push_back(word_arb2cc);
        ack_dat.push_back(dat_arb2cc); ack_cyc.push_back(cyc);
      end
    end
  end

  // memory: acks one cycle after each request; data is 0xA0 + word index
  always begin
    @(negedge clk);
    if (mem_en && rst && req_arb2mem) begin
      resp_a = adr_arb2mem;
      @(posedge clk); #1 resp_ack = 1'b1; resp_dat = 32'hA0 + {30'b0, resp_a[3:2]};
      @(posedge clk); #1 resp_ack = 1'b0; resp_dat = '0;
    end
  end

  // re-requester: pulses req in the last-ack cycle (word 3), once per enabled controller
  always begin
    @(negedge clk);
    if (!rst) begin
      rc[0] = 0; rc[1] = 0;
    end else begin
      fire = 1'b0;
      for (int i = 0; i < 2; i++)
        if (re_en[i] && rc[i] == 0 && ack_arb2cc[i] && word_arb2cc == 2'd3) begin
          req_fair[i] = 1'b1; rc[i]++; fire = 1'b1;
        end
      if (fire) begin
        @(posedge clk); #1 req_fair = '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    @(posedge clk); #1 rst = 1'b0; req_main = '0; re_en = '0; mem_en = 1'b1; tb_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic pulse(input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1);
    @(posedge clk); #1 req_main = r; adr_main = {a1, a0}; t0 = cyc;
    @(posedge clk); #1 req_main = '0;
  endtask

  task automatic wait_acks(input string tag, input int n, input int lim);
    int k = 0;
    while (ack_word.size() < n && k < lim) begin
      @(posedge clk); #2; k++;
    end
    chk(tag, ack_word.size(), n);
  endtask

  logic [31:0] ea [4];
  logic [1:0]  ew [4];
  logic [31:0] ed [4];
  logic [1:0]  ef [4];
  int          n1;

  initial begin
    ea = '{32'h1238, 32'h123C, 32'h1230, 32'h1234};
    ew = '{2'd2, 2'd3, 2'd0, 2'd1};
    ed = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
`ifdef ARB_FIXED_PRIO_EN
    ef = '{2'b01, 2'b01, 2'b10, 2'b10};
`else
    ef = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    repeat (2) @(posedge clk);
    #1 chk("rst_ctl", {req_arb2mem, gnt_arb2cc, ack_arb2cc, word_arb2cc, err_arb}, 64'd0);
    chk("rst_bus", {adr_arb2mem, dat_arb2cc}, 64'd0);
    rst = 1'b1;

    // single miss, critical word first
    pulse(2'b01, 32'h0000_1238, 32'h0);
    wait_acks("t1_acks", 4, 40);
    chk("t1_lat", iss_cyc[0] - t0, 2);
    chk("t1_gnt", iss_gnt[0], 2'b01);
    n1 = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_adr", iss_adr[i], ea[i]);
      chk("t1_word", ack_word[i], ew[i]);
      chk("t1_dat", ack_dat[i], ed[i]);
      n1 += int'(ack_who[i][1]);
    end
    chk("t1_ack1", n1, 0);
    repeat (3) @(posedge clk);
    #2 chk("t1_idle", {req_arb2mem, gnt_arb2cc, err_arb}, 64'd0);

    // simultaneous requests
    do_reset();
    pulse(2'b11, 32'h100, 32'h200);
    wait_acks("t2_acks", 8, 80);
    chk("t2_gnt0", iss_gnt[0], 2'b01);
    chk("t2_gnt1", iss_gnt[4], 2'b10);
    for (int i = 0; i < 4; i++) begin
      chk("t2_adr0", iss_adr[i], 32'h100 + 4 * i);
      chk("t2_adr1", iss_adr[i+4], 32'h200 + 4 * i);
    end
    chk("t2_gap", iss_cyc[4] - ack_cyc[3], 2);
    chk("t2_who", {ack_who[0], ack_who[7]}, 4'b0110);

    // fairness with immediate re-requests
    do_reset();
    re_en = 2'b11;
    pulse(2'b11, 32'h100, 32'h200);
    wait_acks("t3_acks", 16, 200);
    for (int i = 0; i < 4; i++) chk("t3_order", iss_gnt[4*i], ef[i]);
    chk("t3_err", err_arb, 1'b0);

    // reset mid-burst
    do_reset();
    pulse(2'b01, 32'h1238, 32'h0);
    wait_acks("t4_acks", 2, 40);
    mem_en = 1'b0;
    chk("t4_pre", {req_arb2mem, gnt_arb2cc}, 3'b101);
    #1 rst = 1'b0;
    #1 chk("t4_ctl", {req_arb2mem, gnt_arb2cc, ack_arb2cc, word_arb2cc, err_arb}, 64'd0);
    chk("t4_bus", {adr_arb2mem, dat_arb2cc}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 tb_ack = 1'b1; tb_dat = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t4_lateack", ack_arb2cc, 2'b00);
    chk("t4_latedat", dat_arb2cc, 32'h0);
    @(posedge clk); #1 tb_ack = 1'b0; tb_dat = '0;
    chk("t4_err", err_arb, 1'b1);
    repeat (4) @(posedge clk);
    #2 chk("t4_noiss", iss_adr.size(), 0);
    mem_en = 1'b1;

    // repeat request while pending
    do_reset();
    pulse(2'b01, 32'h1238, 32'h0);
    wait_acks("t5_acks1", 1, 40);
    chk("t5_err0", err_arb, 1'b0);
    req_main = 2'b01; adr_main[31:0] = 32'h5550;
    @(posedge clk); #1 req_main = '0;
    #1 chk("t5_err1", err_arb, 1'b1);
    wait_acks("t5_acks", 4, 40);
    for (int i = 0; i < 4; i++) chk("t5_adr", iss_adr[i], ea[i]);
    repeat (8) @(posedge clk);
    #2 chk("t5_noiss", iss_adr.size(), 4);
    chk("t5_sticky", err_arb, 1'b1);

    // new request in the last-ack cycle
    do_reset();
    re_en = 2'b01;
    pulse(2'b01, 32'h100, 32'h0);
    adr_main[31:0] = 32'h300;
    wait_acks("t6_acks", 8, 80);
    for (int i = 0; i < 4; i++) chk("t6_adr", iss_adr[i+4], 32'h300 + 4 * i);
    chk("t6_gap", iss_cyc[4] - ack_cyc[3], 2);
    chk("t6_who", ack_who[7], 2'b01);
    chk("t6_err", err_arb, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
